riscv_str_issue_ctrl: RTL and testbench

// - EX-side initiator for the string-ops unit (riscv_str_ops): accepts one string op per request from EX, drives enable/operator/operand, waits for completion, captures the result.
// - Presents the captured result to writeback via valid/ready; stalls EX while busy.
// - Sequences both single-cycle ops (UPPER/LOWER) and multi-cycle LEET, including the FINISH-state ex_ready handshake.

---
 rtl/riscv_str_issue_ctrl_pkg.sv | 24 ++
 rtl/riscv_str_issue_ctrl_resp_reg.sv | 41 ++++
 rtl/riscv_str_issue_ctrl.sv | 163 ++++++++++++++++
 tb/tb_riscv_str_issue_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_str_issue_ctrl_pkg.sv
// Shared types and constants for the string-ops issue controller.
// Operator encodings mirror the riscv_str_ops unit's operator_i field.
package riscv_str_issue_ctrl_pkg;

    localparam int STR_OP_WIDTH = 2;

    localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 2'd0;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 2'd1;
    localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 2'd2;

    localparam logic [31:0] STR_RESULT_POISON = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } str_issue_state_e;

    function automatic logic str_op_multicycle(input logic [STR_OP_WIDTH-1:0] op);
        return (op == STR_OP_LEET);
    endfunction

endpackage

// File: rtl/riscv_str_issue_ctrl_resp_reg.sv
// Result holding register (32-bit value + poison flag) with a valid/ready
// handshake towards writeback; load wins over consume/clear.
module riscv_str_resp_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_err,
    input  logic        clear,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] data,
    output logic        err
);

    logic        valid_r;
    logic [31:0] data_r;
    logic        err_r;

    // Retiring an entry only drops valid; the payload stays visible until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= 32'h0000_0000;
            err_r   <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            err_r   <= load_err;
        end else if (clear || ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign valid = valid_r;
    assign data  = data_r;
    assign err   = err_r;

endmodule

// File: rtl/riscv_str_issue_ctrl.sv
// EX-side initiator for the riscv_str_ops unit: issue, wait, capture, hand to writeback.
// Optional watchdog enabled by defining RISCV_STR_TIMEOUT_EN.
module riscv_str_issue_ctrl
    import riscv_str_issue_ctrl_pkg::*;
#(
    parameter int CNT_W          = 4,
    parameter int TIMEOUT_CYCLES = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    input  logic [STR_OP_WIDTH-1:0] req_op_i,
    input  logic [31:0]             req_operand_i,
    output logic                    req_ready_o,
    input  logic                    flush_i,
    output logic                    str_en_o,
    output logic [STR_OP_WIDTH-1:0] str_op_o,
    output logic [31:0]             str_operand_o,
    input  logic [31:0]             str_result_i,
    input  logic                    str_ready_i,
    output logic                    str_ex_ready_o,
    output logic                    wb_valid_o,
    output logic [31:0]             wb_result_o,
    output logic                    wb_err_o,
    input  logic                    wb_ready_i,
    output logic                    busy_o
);

`ifdef RISCV_STR_TIMEOUT_EN
    localparam logic TIMEOUT_EN = 1'b1;
    if (TIMEOUT_CYCLES >= (32'd1 << CNT_W) - 32'd1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be below the saturating counter maximum");
    end
`else
    localparam logic TIMEOUT_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = TIMEOUT_CYCLES[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    str_issue_state_e        state_r;
    str_issue_state_e        state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [STR_OP_WIDTH-1:0] op_r;
    logic [31:0]             operand_r;

    logic        accept_s;
    logic        capture_s;
    logic        timeout_s;
    logic        load_s;
    logic [31:0] load_data_s;
    logic        resp_clear_s;

    // State register, request latch and saturating exec-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            op_r      <= '0;
            operand_r <= 32'h0000_0000;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                op_r      <= req_op_i;
                operand_r <= req_operand_i;
                cnt_r     <= '0;
            end else if ((state_r == EXEC) && (cnt_r != '1)) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next state and unit-side handshake; flush outranks both capture and accept.
    always_comb begin
        state_s        = state_r;
        accept_s       = 1'b0;
        capture_s      = 1'b0;
        timeout_s      = 1'b0;
        req_ready_o    = 1'b0;
        str_en_o       = 1'b0;
        str_ex_ready_o = 1'b1;
        case (state_r)
            IDLE: begin
                req_ready_o = !flush_i;
                accept_s    = req_valid_i && !flush_i;
                if (accept_s) begin
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                str_en_o = 1'b1;
                // A LEET result is only trusted once the unit has left IDLE (counter past issue).
                if (str_op_multicycle(op_r)) begin
                    capture_s = !flush_i && (cnt_r != '0) && str_ready_i;
                end else begin
                    capture_s = !flush_i && (cnt_r == CNT_ONE);
                end
                timeout_s      = TIMEOUT_EN && !flush_i && !capture_s && (cnt_r == TIMEOUT_CNT);
                str_ex_ready_o = capture_s || timeout_s;
                if (flush_i) begin
                    if (str_op_multicycle(op_r)) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = IDLE;
                    end
                end else if (capture_s || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = EXEC;
                end
            end
            RESP: begin
                req_ready_o = wb_ready_i && !flush_i;
                accept_s    = req_valid_i && wb_ready_i && !flush_i;
                if (flush_i) begin
                    state_s = IDLE;
                end else if (accept_s) begin
                    state_s = EXEC;
                end else if (wb_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            DRAIN: begin
                if (str_ready_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign busy_o        = (state_r != IDLE);
    assign str_op_o      = op_r;
    assign str_operand_o = operand_r;

    assign load_s       = capture_s || timeout_s;
    assign load_data_s  = timeout_s ? STR_RESULT_POISON : str_result_i;
    assign resp_clear_s = flush_i && (state_r == RESP);

    riscv_str_resp_reg u_resp_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_s),
        .load_data (load_data_s),
        .load_err  (timeout_s),
        .clear     (resp_clear_s),
        .ready     (wb_ready_i),
        .valid     (wb_valid_o),
        .data      (wb_result_o),
        .err       (wb_err_o)
    );

endmodule

// File: tb/tb_riscv_str_issue_ctrl.sv
// Directed self-checking bench for riscv_str_issue_ctrl; the bench plays the string unit.
// ctl_s packs {req_ready, str_en, str_ex_ready, wb_valid, wb_err, busy}.
module tb_riscv_str_issue_ctrl;
    import riscv_str_issue_ctrl_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    req_valid_i;
    logic [STR_OP_WIDTH-1:0] req_op_i;
    logic [31:0]             req_operand_i;
    logic                    req_ready_o;
    logic                    flush_i;
    logic                    str_en_o;
    logic [STR_OP_WIDTH-1:0] str_op_o;
    logic [31:0]             str_operand_o;
    logic [31:0]             str_result_i;
    logic                    str_ready_i;
    logic                    str_ex_ready_o;
    logic                    wb_valid_o;
    logic [31:0]             wb_result_o;
    logic                    wb_err_o;
    logic                    wb_ready_i;
    logic                    busy_o;
    logic [5:0]              ctl_s;
    int                      n_checks = 0;
    int                      n_fails  = 0;

    riscv_str_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_op_i(req_op_i), .req_operand_i(req_operand_i),
        .req_ready_o(req_ready_o), .flush_i(flush_i),
        .str_en_o(str_en_o), .str_op_o(str_op_o), .str_operand_o(str_operand_o),
        .str_result_i(str_result_i), .str_ready_i(str_ready_i), .str_ex_ready_o(str_ex_ready_o),
        .wb_valid_o(wb_valid_o), .wb_result_o(wb_result_o), .wb_err_o(wb_err_o),
        .wb_ready_i(wb_ready_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    assign ctl_s = {req_ready_o, str_en_o, str_ex_ready_o, wb_valid_o, wb_err_o, busy_o};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = STR_OP_UPPER; req_operand_i = 32'h0;
        flush_i = 1'b0; str_result_i = 32'h0; str_ready_i = 1'b1; wb_ready_i = 1'b1;
        #2;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL reset_ctl: got %b expected %b", ctl_s, 6'b101000); end
        n_checks++; if ({str_op_o, str_operand_o, wb_result_o} !== 66'h0) begin n_fails++; $display("FAIL reset_data: op=%h operand=%h result=%h expected all zero", str_op_o, str_operand_o, wb_result_o); end
        step(); step();
        rst_n = 1'b1;
        #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL reset_release: got %b expected %b", ctl_s, 6'b101000); end
    endtask

    task automatic test_upper;
        req_valid_i = 1'b1; req_op_i = STR_OP_UPPER; req_operand_i = 32'h61624344; wb_ready_i = 1'b1;
        #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL upper_accept: got %b expected %b", ctl_s, 6'b101000); end
        step(); req_valid_i = 1'b0; str_result_i = 32'h0; #1;
        n_checks++; if (ctl_s !== 6'b010001) begin n_fails++; $display("FAIL upper_issue: got %b expected %b", ctl_s, 6'b010001); end
        n_checks++; if ({str_op_o, str_operand_o} !== {STR_OP_UPPER, 32'h61624344}) begin n_fails++; $display("FAIL upper_drive: got %h/%h expected %h/%h", str_op_o, str_operand_o, STR_OP_UPPER, 32'h61624344); end
        step(); str_result_i = 32'h41424344; #1;
        n_checks++; if (ctl_s !== 6'b011001) begin n_fails++; $display("FAIL upper_capture: got %b expected %b", ctl_s, 6'b011001); end
        step(); str_result_i = 32'h0; #1;
        n_checks++; if (ctl_s !== 6'b101101) begin n_fails++; $display("FAIL upper_resp: got %b expected %b", ctl_s, 6'b101101); end
        n_checks++; if (wb_result_o !== 32'h41424344) begin n_fails++; $display("FAIL upper_result: got %h expected %h", wb_result_o, 32'h41424344); end
        step(); #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL upper_idle: got %b expected %b", ctl_s, 6'b101000); end
    endtask

    task automatic test_leet_hold_back_to_back;
        req_valid_i = 1'b1; req_op_i = STR_OP_LEET; req_operand_i = 32'h6C657373;
        wb_ready_i = 1'b0; str_ready_i = 1'b1;
        step(); req_valid_i = 1'b0; #1;
        n_checks++; if ({ctl_s, str_op_o} !== {6'b010001, STR_OP_LEET}) begin n_fails++; $display("FAIL leet_issue: got %b/%h expected %b/%h", ctl_s, str_op_o, 6'b010001, STR_OP_LEET); end
        for (int i = 1; i < 4; i++) begin
            step(); str_ready_i = 1'b0; #1;
            n_checks++; if (ctl_s !== 6'b010001) begin n_fails++; $display("FAIL leet_wait%0d: got %b expected %b", i, ctl_s, 6'b010001); end
        end
        step(); str_ready_i = 1'b1; str_result_i = 32'h31333535; #1;
        n_checks++; if (ctl_s !== 6'b011001) begin n_fails++; $display("FAIL leet_capture: got %b expected %b", ctl_s, 6'b011001); end
        for (int i = 0; i < 3; i++) begin
            step(); str_result_i = 32'h0; #1;
            n_checks++; if ({ctl_s, wb_result_o} !== {6'b001101, 32'h31333535}) begin n_fails++; $display("FAIL leet_hold%0d: got %b/%h expected %b/%h", i, ctl_s, wb_result_o, 6'b001101, 32'h31333535); end
        end
        step(); wb_ready_i = 1'b1; req_valid_i = 1'b1; req_op_i = STR_OP_UPPER; req_operand_i = 32'h7A5A2131; #1;
        n_checks++; if ({ctl_s, wb_result_o} !== {6'b101101, 32'h31333535}) begin n_fails++; $display("FAIL b2b_consume: got %b/%h expected %b/%h", ctl_s, wb_result_o, 6'b101101, 32'h31333535); end
        step(); req_valid_i = 1'b0; #1;
        n_checks++; if ({ctl_s, str_operand_o} !== {6'b010001, 32'h7A5A2131}) begin n_fails++; $display("FAIL b2b_issue: got %b/%h expected %b/%h", ctl_s, str_operand_o, 6'b010001, 32'h7A5A2131); end
        step(); str_result_i = 32'h5A5A2131; #1;
        n_checks++; if (ctl_s !== 6'b011001) begin n_fails++; $display("FAIL b2b_capture: got %b expected %b", ctl_s, 6'b011001); end
        step(); str_result_i = 32'h0; #1;
        n_checks++; if ({ctl_s, wb_result_o} !== {6'b101101, 32'h5A5A2131}) begin n_fails++; $display("FAIL b2b_resp: got %b/%h expected %b/%h", ctl_s, wb_result_o, 6'b101101, 32'h5A5A2131); end
        step(); #1;
    endtask

    task automatic test_flush;
        req_valid_i = 1'b1; req_op_i = STR_OP_UPPER; req_operand_i = 32'h11111111; flush_i = 1'b1; #1;
        n_checks++; if (ctl_s !== 6'b001000) begin n_fails++; $display("FAIL flush_idle: got %b expected %b", ctl_s, 6'b001000); end
        step(); req_valid_i = 1'b0; flush_i = 1'b0; #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL flush_idle_stay: got %b expected %b", ctl_s, 6'b101000); end
        req_valid_i = 1'b1; req_op_i = STR_OP_LEET; req_operand_i = 32'h6C657373; str_ready_i = 1'b1;
        step(); req_valid_i = 1'b0; #1;
        step(); str_ready_i = 1'b0; #1;
        step(); flush_i = 1'b1; #1;
        n_checks++; if (ctl_s !== 6'b010001) begin n_fails++; $display("FAIL flush_leet_exec: got %b expected %b", ctl_s, 6'b010001); end
        step(); flush_i = 1'b0; #1;
        n_checks++; if (ctl_s !== 6'b001001) begin n_fails++; $display("FAIL flush_drain: got %b expected %b", ctl_s, 6'b001001); end
        step(); #1;
        n_checks++; if (ctl_s !== 6'b001001) begin n_fails++; $display("FAIL flush_drain_wait: got %b expected %b", ctl_s, 6'b001001); end
        step(); str_ready_i = 1'b1; #1;
        step(); #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL flush_drain_exit: got %b expected %b", ctl_s, 6'b101000); end
        req_valid_i = 1'b1; req_op_i = STR_OP_UPPER; req_operand_i = 32'h61624344;
        step(); req_valid_i = 1'b0; #1;
        step(); str_result_i = 32'h41424344; #1;
        step(); str_result_i = 32'h0; wb_ready_i = 1'b0; #1;
        n_checks++; if ({ctl_s, wb_result_o} !== {6'b001101, 32'h41424344}) begin n_fails++; $display("FAIL flush_after_upper: got %b/%h expected %b/%h", ctl_s, wb_result_o, 6'b001101, 32'h41424344); end
        flush_i = 1'b1; req_valid_i = 1'b1; #1;
        n_checks++; if (ctl_s !== 6'b001101) begin n_fails++; $display("FAIL flush_resp: got %b expected %b", ctl_s, 6'b001101); end
        step(); flush_i = 1'b0; req_valid_i = 1'b0; wb_ready_i = 1'b1; #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL flush_resp_drop: got %b expected %b", ctl_s, 6'b101000); end
        req_valid_i = 1'b1; req_op_i = STR_OP_LOWER; req_operand_i = 32'h41424344;
        step(); req_valid_i = 1'b0; flush_i = 1'b1; #1;
        step(); flush_i = 1'b0; #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL flush_single_exec: got %b expected %b", ctl_s, 6'b101000); end
    endtask

    task automatic test_other_op;
        logic [STR_OP_WIDTH-1:0] op_other;
        op_other = 2'd3;
        req_valid_i = 1'b1; req_op_i = op_other; req_operand_i = 32'h12345678;
        step(); req_valid_i = 1'b0; #1;
        step(); str_result_i = STR_RESULT_POISON; #1;
        n_checks++; if (ctl_s !== 6'b011001) begin n_fails++; $display("FAIL other_capture: got %b expected %b", ctl_s, 6'b011001); end
        step(); str_result_i = 32'h0; #1;
        n_checks++; if ({ctl_s, wb_result_o} !== {6'b101101, 32'hDEADBEEF}) begin n_fails++; $display("FAIL other_resp: got %b/%h expected %b/%h", ctl_s, wb_result_o, 6'b101101, 32'hDEADBEEF); end
        step(); #1;
    endtask

    task automatic test_reset_mid_leet;
        req_valid_i = 1'b1; req_op_i = STR_OP_LEET; req_operand_i = 32'h6C657373; str_ready_i = 1'b1;
        step(); req_valid_i = 1'b0; #1;
        step(); str_ready_i = 1'b0; #1;
        step(); rst_n = 1'b0; #1;
        n_checks++; if (ctl_s !== 6'b101000) begin n_fails++; $display("FAIL rst_mid_ctl: got %b expected %b", ctl_s, 6'b101000); end
        n_checks++; if ({str_op_o, str_operand_o, wb_result_o} !== 66'h0) begin n_fails++; $display("FAIL rst_mid_data: op=%h operand=%h result=%h expected all zero", str_op_o, str_operand_o, wb_result_o); end
        step(); rst_n = 1'b1; str_ready_i = 1'b1; #1;
        req_valid_i = 1'b1;
        step(); req_valid_i = 1'b0; #1;
        step(); str_ready_i = 1'b0; #1;
        step(); #1;
        step(); #1;
        step(); str_ready_i = 1'b1; str_result_i = 32'h31333535; #1;
        n_checks++; if (ctl_s !== 6'b011001) begin n_fails++; $display("FAIL rst_leet_capture: got %b expected %b", ctl_s, 6'b011001); end
        step(); str_result_i = 32'h0; #1;
        n_checks++; if ({ctl_s, wb_result_o} !== {6'b101101, 32'h31333535}) begin n_fails++; $display("FAIL rst_leet_resp: got %b/%h expected %b/%h", ctl_s, wb_result_o, 6'b101101, 32'h31333535); end
        step(); #1;
    endtask

`ifdef RISCV_STR_TIMEOUT_EN
    task automatic test_timeout;
        req_valid_i = 1'b1; req_op_i = STR_OP_LEET; req_operand_i = 32'h6C657373; str_ready_i = 1'b0;
        step(); req_valid_i = 1'b0; #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin step(); #1; end
            n_checks++; if (ctl_s !== 6'b010001) begin n_fails++; $display("FAIL timeout_wait%0d: got %b expected %b", c, ctl_s, 6'b010001); end
        end
        step(); #1;
        n_checks++; if (ctl_s !== 6'b011001) begin n_fails++; $display("FAIL timeout_fire: got %b expected %b", ctl_s, 6'b011001); end
        step(); #1;
        n_checks++; if ({ctl_s, wb_result_o} !== {6'b101111, 32'hDEADBEEF}) begin n_fails++; $display("FAIL timeout_resp: got %b/%h expected %b/%h", ctl_s, wb_result_o, 6'b101111, 32'hDEADBEEF); end
        step(); str_ready_i = 1'b1; #1;
    endtask
`endif

    initial begin
        test_reset();
        test_upper();
        test_leet_hold_back_to_back();
        test_flush();
        test_other_op();
        test_reset_mid_leet();
`ifdef RISCV_STR_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "bench did not complete");
    end

endmodule
